pipe_skid_register: RTL and testbench

Parametrised pipeline-stage register with a valid/ready handshake, a one-entry skid buffer and synchronous flush. It replaces the plain load-enable stage register between LEGv8 pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB). It sustains one transfer per cycle under back-pressure, with registered `in_ready` and no combinational ready path from `out_ready`. It also supports squashing in-flight contents on branch mispredict.

---
 rtl/pipe_pkg.sv | 17 +
 rtl/pipe_data_reg.sv | 21 ++
 rtl/pipe_skid_register.sv | 109 ++++++++++
 tb/tb_pipe_skid_register.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the skid-buffered pipeline stage register.
// State encoding and default payload width.
package pipe_pkg;

   localparam logic [1:0] ST_EMPTY = 2'd0;
   localparam logic [1:0] ST_ONE   = 2'd1;
   localparam logic [1:0] ST_TWO   = 2'd2;

   localparam int PIPE_W_DEFAULT = 64;

   typedef enum logic [1:0] {
      S_EMPTY = ST_EMPTY,
      S_ONE   = ST_ONE,
      S_TWO   = ST_TWO
   } pipe_state_e;

endpackage

// File: rtl/pipe_data_reg.sv
// N-bit load-enable register with asynchronous active-high clear.
// Holds one payload entry of the skid-buffered stage.
module pipe_data_reg #(
   parameter int N = 64
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         en,
   input  logic [N-1:0] d,
   output logic [N-1:0] q
);

   // NOTE: payload is cleared on reset too, so out_data reads zero straight out of reset instead of X.
   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         q <= '0;
      else if (en)
         q <= d;
   end

endmodule

// File: rtl/pipe_skid_register.sv
// Pipeline-stage register with valid/ready handshake, one-entry skid buffer
// and synchronous flush; in_ready is a pure function of registered state.
module pipe_skid_register
   import pipe_pkg::*;
#(
   parameter int N = PIPE_W_DEFAULT
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         in_valid,
   input  logic [N-1:0] in_data,
   output logic         in_ready,
   output logic         out_valid,
   output logic [N-1:0] out_data,
   input  logic         out_ready,
   input  logic         flush,
   output logic [1:0]   occupancy
);

   pipe_state_e  state;
   pipe_state_e  state_next;
   logic         main_v;
   logic         skid_v;
   logic         accept;
   logic         take;
   logic         main_en;
   logic         main_from_skid;
   logic         skid_en;
   logic [N-1:0] main_d;
   logic [N-1:0] main_q;
   logic [N-1:0] skid_q;

   // Valid bits are decoded from state, so skid_v without main_v cannot be expressed.
   assign main_v    = (state == S_ONE) || (state == S_TWO);
   assign skid_v    = (state == S_TWO);
   assign in_ready  = ~skid_v;
   assign out_valid = main_v;
   assign out_data  = main_q;
   assign occupancy = {1'b0, main_v} + {1'b0, skid_v};

   assign accept = in_valid & in_ready;
   assign take   = main_v & out_ready;

   // NOTE: non-blocking assignment so every flop samples the pre-edge values.
   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         state <= S_EMPTY;
      else
         state <= state_next;
   end

   // NOTE: defaults first, so no path leaves an output unassigned and infers a latch.
   always_comb begin
      state_next     = state;
      main_en        = 1'b0;
      main_from_skid = 1'b0;
      skid_en        = 1'b0;
      if (flush) begin
         state_next = S_EMPTY;
      end else begin
         unique case (state)
            S_EMPTY: begin
               if (accept) begin
                  main_en    = 1'b1;
                  state_next = S_ONE;
               end
            end
            S_ONE: begin
               if (accept && take) begin
                  main_en = 1'b1;
               end else if (accept) begin
                  skid_en    = 1'b1;
                  state_next = S_TWO;
               end else if (take) begin
                  state_next = S_EMPTY;
               end
            end
            S_TWO: begin
               // Skid is always the younger entry; it moves up when main is taken.
               if (take) begin
                  main_en        = 1'b1;
                  main_from_skid = 1'b1;
                  state_next     = S_ONE;
               end
            end
            default: state_next = S_EMPTY;
         endcase
      end
   end

   assign main_d = main_from_skid ? skid_q : in_data;

   pipe_data_reg #(.N(N)) main (
      .clock (clock),
      .reset (reset),
      .en    (main_en),
      .d     (main_d),
      .q     (main_q)
   );

   pipe_data_reg #(.N(N)) skid (
      .clock (clock),
      .reset (reset),
      .en    (skid_en),
      .d     (in_data),
      .q     (skid_q)
   );

endmodule

// File: tb/tb_pipe_skid_register.sv
// Scoreboard bench: three stages (N=64, 8, 1) share one stimulus stream; an
// occupancy model checks flags every cycle and a monitor checks every take.
module tb_pipe_skid_register;

   logic        clock = 1'b0;
   logic        reset;
   logic        in_valid;
   logic [63:0] in_data;
   logic        out_ready;
   logic        flush;

   logic        in_ready64, out_valid64;
   logic [63:0] out_data64;
   logic [1:0]  occ64;
   logic        in_ready8, out_valid8;
   logic [7:0]  out_data8;
   logic [1:0]  occ8;
   logic        in_ready1, out_valid1;
   logic [0:0]  out_data1;
   logic [1:0]  occ1;

   int          errors = 0;
   int          checks = 0;
   int          m_cnt  = 0;
   logic [63:0] exp_q[$];
   logic [63:0] mon_exp;

   always #5 clock = ~clock;

   pipe_skid_register #(.N(64)) dut64 (
      .clock(clock), .reset(reset), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready64), .out_valid(out_valid64), .out_data(out_data64),
      .out_ready(out_ready), .flush(flush), .occupancy(occ64));

   pipe_skid_register #(.N(8)) dut8 (
      .clock(clock), .reset(reset), .in_valid(in_valid), .in_data(in_data[7:0]),
      .in_ready(in_ready8), .out_valid(out_valid8), .out_data(out_data8),
      .out_ready(out_ready), .flush(flush), .occupancy(occ8));

   pipe_skid_register #(.N(1)) dut1 (
      .clock(clock), .reset(reset), .in_valid(in_valid), .in_data(in_data[0:0]),
      .in_ready(in_ready1), .out_valid(out_valid1), .out_data(out_data1),
      .out_ready(out_ready), .flush(flush), .occupancy(occ1));

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Flags of all three widths against the bench's own occupancy count.
   task automatic check_state();
      logic       rdy;
      logic       vld;
      logic [1:0] occ;
      rdy = (m_cnt < 2);
      vld = (m_cnt > 0);
      occ = 2'(m_cnt);
      check("in_ready64",  64'(in_ready64),  64'(rdy));
      check("out_valid64", 64'(out_valid64), 64'(vld));
      check("occupancy64", 64'(occ64),       64'(occ));
      check("flags8", 64'({in_ready8, out_valid8, occ8}), 64'({rdy, vld, occ}));
      check("flags1", 64'({in_ready1, out_valid1, occ1}), 64'({rdy, vld, occ}));
   endtask

   // Drive one cycle, then advance the model by the handshake the edge just saw.
   task automatic step(input logic v, input logic [63:0] d, input logic r, input logic f);
      logic acc;
      logic tk;
      in_valid  = v;
      in_data   = d;
      out_ready = r;
      flush     = f;
      @(posedge clock);
      #1;
      acc = v && (m_cnt < 2);
      tk  = r && (m_cnt > 0);
      if (f) begin
         m_cnt = 0;
         exp_q.delete();
      end else begin
         m_cnt = m_cnt + int'(acc) - int'(tk);
         if (acc) exp_q.push_back(d);
      end
      check_state();
   endtask

   // Monitor: every take pops the oldest expected entry, mid-cycle.
   always @(negedge clock) begin
      if (!reset && out_valid64 && out_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: got %h, required no output pending", out_data64);
         end else begin
            mon_exp = exp_q.pop_front();
            check("out_data64", out_data64,        mon_exp);
            check("out_data8",  64'(out_data8),    64'(mon_exp[7:0]));
            check("out_data1",  64'(out_data1),    64'(mon_exp[0]));
         end
      end
   end

   initial begin
      reset     = 1'b1;
      in_valid  = 1'b1;
      in_data   = 64'hDEAD_BEEF;
      out_ready = 1'b1;
      flush     = 1'b0;

      // Reset held across an edge with in_valid high.
      #12;
      check("rst_out_valid", 64'(out_valid64), 64'd0);
      check("rst_out_data",  out_data64,       64'd0);
      check("rst_in_ready",  64'(in_ready64),  64'd1);
      check("rst_occupancy", 64'(occ64),       64'd0);
      #1 reset = 1'b0;
      step(1'b1, 64'hDEAD_BEEF, 1'b1, 1'b0);
      step(1'b0, 64'h0, 1'b1, 1'b0);

      // Back-to-back streaming, no bubbles.
      for (int i = 1; i <= 8; i++) step(1'b1, 64'(i), 1'b1, 1'b0);
      step(1'b0, 64'h0, 1'b1, 1'b0);

      // Stall fills skid; a third offer is refused while full.
      step(1'b1, 64'hA, 1'b0, 1'b0);
      step(1'b1, 64'hB, 1'b0, 1'b0);
      step(1'b1, 64'hD, 1'b0, 1'b0);
      step(1'b0, 64'h0, 1'b1, 1'b0);
      step(1'b0, 64'h0, 1'b1, 1'b0);

      // Flush in TWO with a same-cycle offer of 0xC.
      step(1'b1, 64'hA, 1'b0, 1'b0);
      step(1'b1, 64'hB, 1'b0, 1'b0);
      step(1'b1, 64'hC, 1'b0, 1'b1);
      check("flush_out_data", out_data64, 64'hA);
      step(1'b0, 64'h0, 1'b1, 1'b0);

      // Asynchronous reset pulse between edges while in TWO.
      step(1'b1, 64'hA, 1'b0, 1'b0);
      step(1'b1, 64'hB, 1'b0, 1'b0);
      in_valid = 1'b0;
      #2 reset = 1'b1;
      #1;
      m_cnt = 0;
      exp_q.delete();
      check_state();
      check("arst_out_data", out_data64, 64'd0);
      #1 reset = 1'b0;
      step(1'b1, 64'h77, 1'b1, 1'b0);
      step(1'b0, 64'h0, 1'b1, 1'b0);

      // Randomised valid/ready with occasional flush.
      for (int i = 0; i < 400; i++)
         step(1'($urandom_range(0, 1)), {$urandom, $urandom},
              1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 31) == 0));

      // Drain: everything accepted must have come out.
      for (int i = 0; i < 4; i++) step(1'b0, 64'h0, 1'b1, 1'b0);
      check("drain_pending", 64'(exp_q.size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
